icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache with 16-bit words and a zero-latency
// combinational lookup; misses fill the whole line one word at a time from backing memory.
module icache #(
  parameter int SETS  = 32,
  parameter int WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        stall,
  input  logic        inval,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_valid
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 15 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0]   fill_index_q, fill_index_d;
  logic               inval_pend_q, inval_pend_d;
  logic [SETS-1:0]    valid_q;

  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [15:0]        data_q [SETS*WORDS];

  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               lookup_hit;
  logic               word_we;
  logic               fill_done;
  logic               clr_all;
  logic               unused_addr_lsb;

  assign req_off         = fetch_addr[OFF_W:1];
  assign req_index       = fetch_addr[OFF_W+IDX_W:OFF_W+1];
  assign req_tag         = fetch_addr[15:OFF_W+IDX_W+1];
  assign unused_addr_lsb = fetch_addr[0];

  assign lookup_hit = valid_q[req_index] && (tag_q[req_index] == req_tag);

  // Reset gating keeps stall low while the cache is held in reset.
  assign stall = fetch_req & ~instr_valid & rst_n;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_tag_d   = fill_tag_q;
    fill_index_d = fill_index_q;
    inval_pend_d = inval_pend_q;
    instr_valid  = 1'b0;
    instr        = 16'h0000;
    mem_rd       = 1'b0;
    mem_addr     = 16'h0000;
    word_we      = 1'b0;
    fill_done    = 1'b0;
    clr_all      = 1'b0;

    case (state_q)
      IDLE: begin
        instr_valid = fetch_req & lookup_hit;
        if (instr_valid) begin
          instr = data_q[{req_index, req_off}];
        end
        if (inval) begin
          clr_all = 1'b1;
        end else if (fetch_req && !lookup_hit) begin
          state_d      = FILL;
          fill_tag_d   = req_tag;
          fill_index_d = req_index;
          cnt_d        = '0;
        end
      end
      FILL: begin
        mem_rd   = 1'b1;
        mem_addr = {fill_tag_q, fill_index_q, cnt_q, 1'b0};
        if (inval) begin
          inval_pend_d = 1'b1;
        end
        if (mem_valid) begin
          word_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            // An invalidate seen at any point of the fill also wipes the new line.
            fill_done    = 1'b1;
            clr_all      = inval_pend_q | inval;
            inval_pend_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
      inval_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_tag_q   <= fill_tag_d;
      fill_index_q <= fill_index_d;
      inval_pend_q <= inval_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we) begin
      data_q[{fill_index_q, cnt_q}] <= mem_data;
    end
    if (fill_done) begin
      tag_q[fill_index_q] <= fill_tag_q;
    end
  end

  for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[gi] <= 1'b0;
      end else if (clr_all) begin
        valid_q[gi] <= 1'b0;
      end else if (fill_done && (fill_index_q == IDX_W'(gi))) begin
        valid_q[gi] <= 1'b1;
      end
    end
  end

endmodule
